// File: rtl/scene_image_renderer_pkg.sv
// Shared types and constants for the scene image renderer and the scene mux.
// Holds the fade FSM encoding, the RGB444 and VGA sizes, and the per-channel dim helper.
package scene_image_renderer_pkg;

  localparam int RGB_W    = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int                  LEVEL_W   = 5;
  localparam logic [LEVEL_W-1:0]  LEVEL_MAX = 5'd16;

  typedef enum logic [1:0] {
    ST_BLACK,
    ST_FADE_IN,
    ST_SHOW,
    ST_FADE_OUT
  } fade_state_e;

  // (c*L)>>4 with L in 0..16; the product never exceeds 8 bits.
  function automatic logic [3:0] dim_channel(input logic [3:0]         c,
                                             input logic [LEVEL_W-1:0] l);
    logic [7:0] prod;
    prod = 8'(c) * 8'(l);
    return 4'(prod >> 4);
  endfunction

endpackage

// File: rtl/scene_image_renderer_rgb_dimmer.sv
// Combinational RGB444 brightness scaler, out = (c*L)>>4 per channel.
// L=16 passes the colour through unchanged; L=0 gives black.
module rgb_dimmer
  import scene_image_renderer_pkg::*;
(
  input  logic [RGB_W-1:0]   i_rgb,
  input  logic [LEVEL_W-1:0] i_level,
  output logic [RGB_W-1:0]   o_rgb
);

  assign o_rgb = {dim_channel(i_rgb[11:8], i_level),
                  dim_channel(i_rgb[7:4],  i_level),
                  dim_channel(i_rgb[3:0],  i_level)};

endmodule

// File: rtl/scene_image_renderer.sv
// Full-scene image renderer: VGA position to ROM address, ROM-latency-aligned pixel
// select with chroma key and background, and a frame-synchronous fade state machine.
module scene_image_renderer
  import scene_image_renderer_pkg::*;
#(
  parameter int               IMG_W       = 320,
  parameter int               IMG_H       = 240,
  parameter int               ADDR_W      = 17,
  parameter int               SCALE_SHIFT = 1,
  parameter int               X0          = 0,
  parameter int               Y0          = 0,
  parameter int               MEM_LAT     = 1,
  parameter logic [RGB_W-1:0] KEY_COLOR   = 12'hF0F,
  parameter logic [RGB_W-1:0] BG_COLOR    = 12'h000,
  parameter int               FADE_DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic              fade_in,
  input  logic              fade_out,
  input  logic [RGB_W-1:0]  mem_data,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [RGB_W-1:0]  vga_data,
  output logic              busy,
  output logic              done
);

  localparam int               WIN_W    = IMG_W << SCALE_SHIFT;
  localparam int               WIN_H    = IMG_H << SCALE_SHIFT;
  localparam int               DLY      = 1 + MEM_LAT;
  localparam int               DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

  // ---------------- address generation ----------------
  int                w_h, w_v, w_sx, w_sy;
  logic              w_in_win;
  logic [ADDR_W-1:0] w_addr;

  assign w_h      = int'(h_cnt);
  assign w_v      = int'(v_cnt);
  assign w_in_win = (w_h >= X0) && (w_h < X0 + WIN_W) &&
                    (w_v >= Y0) && (w_v < Y0 + WIN_H);
  assign w_sx     = (w_h - X0) >>> SCALE_SHIFT;
  assign w_sy     = (w_v - Y0) >>> SCALE_SHIFT;
  assign w_addr   = w_in_win ? ADDR_W'(w_sy * IMG_W + w_sx) : '0;

  // ---------------- pixel pipeline ----------------
  logic [ADDR_W-1:0]  r_pixel_addr;
  logic [DLY-1:0]     r_valid_sr, r_win_sr;
  logic [RGB_W-1:0]   r_vga;
  logic [RGB_W-1:0]   w_pix, w_dim;
  logic [LEVEL_W-1:0] r_level;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel_addr <= '0;
      r_valid_sr   <= '0;
      r_win_sr     <= '0;
      r_vga        <= '0;
    end else begin
      r_pixel_addr <= w_addr;
      r_valid_sr   <= {r_valid_sr[DLY-2:0], valid};
      r_win_sr     <= {r_win_sr[DLY-2:0], w_in_win};
      r_vga        <= w_dim;
    end
  end

  // NOTE: assigning a default first in always_comb keeps every path driven, so no latch is inferred.
  always_comb begin
    w_pix = mem_data;
    if (!r_valid_sr[DLY-1]) begin
      w_pix = '0;
    end else if (!r_win_sr[DLY-1] || (mem_data == KEY_COLOR)) begin
      w_pix = BG_COLOR;
    end
  end

  rgb_dimmer u_dimmer (
    .i_rgb   (w_pix),
    .i_level (r_level),
    .o_rgb   (w_dim)
  );

  // ---------------- frame tick ----------------
  logic r_at_origin, r_at_origin_d;
  logic w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_at_origin   <= 1'b0;
      r_at_origin_d <= 1'b0;
    end else begin
      r_at_origin   <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      r_at_origin_d <= r_at_origin;
    end
  end

  assign w_tick = r_at_origin && !r_at_origin_d;

  // ---------------- fade FSM ----------------
  fade_state_e        r_state, w_state_nxt;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_done, w_done_nxt;
  logic               w_step;

  assign w_step = w_tick && (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLACK;
      r_level <= '0;
      r_div   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_div   <= w_div_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_div_nxt   = r_div;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_BLACK: begin
        if (fade_in) w_state_nxt = ST_FADE_IN;
      end
      ST_SHOW: begin
        if (fade_out && !fade_in) w_state_nxt = ST_FADE_OUT;
      end
      ST_FADE_IN: begin
        if (fade_out && !fade_in) begin
          w_state_nxt = ST_FADE_OUT;
        end else if (w_step) begin
          w_div_nxt = '0;
          if (r_level >= LEVEL_MAX - 5'd1) begin
            w_level_nxt = LEVEL_MAX;
            w_state_nxt = ST_SHOW;
            w_done_nxt  = 1'b1;
          end else begin
            w_level_nxt = r_level + 5'd1;
          end
        end else if (w_tick) begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      ST_FADE_OUT: begin
        if (fade_in) begin
          w_state_nxt = ST_FADE_IN;
        end else if (w_step) begin
          w_div_nxt = '0;
          if (r_level <= 5'd1) begin
            w_level_nxt = '0;
            w_state_nxt = ST_BLACK;
            w_done_nxt  = 1'b1;
          end else begin
            w_level_nxt = r_level - 5'd1;
          end
        end else if (w_tick) begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: w_state_nxt = ST_BLACK;
    endcase
    // A fresh state always starts counting frames from zero.
    if (w_state_nxt != r_state) w_div_nxt = '0;
  end

  assign pixel_addr = r_pixel_addr;
  assign vga_data   = r_vga;
  assign busy       = (r_state == ST_FADE_IN) || (r_state == ST_FADE_OUT);
  assign done       = r_done;

endmodule

// File: tb/tb_scene_image_renderer.sv
// Directed self-checking bench: one default-parameter instance for address mapping and one
// offset/unscaled instance (FADE_DIV=1, BG 12'h123) for pixel select, latency and fades.
module tb_scene_image_renderer;

  logic        clk;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid, fade_in, fade_out;
  logic [11:0] mem_data;

  logic [16:0] def_addr, dut_addr;
  logic [11:0] def_vga, dut_vga;
  logic        def_busy, dut_busy, def_done, dut_done;

  int n_checks = 0;
  int n_fail   = 0;

  scene_image_renderer u_def (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .fade_in(fade_in), .fade_out(fade_out), .mem_data(mem_data),
    .pixel_addr(def_addr), .vga_data(def_vga), .busy(def_busy), .done(def_done)
  );

  scene_image_renderer #(
    .X0(64), .Y0(32), .SCALE_SHIFT(0), .FADE_DIV(1), .BG_COLOR(12'h123)
  ) u_dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .fade_in(fade_in), .fade_out(fade_out), .mem_data(mem_data),
    .pixel_addr(dut_addr), .vga_data(dut_vga), .busy(dut_busy), .done(dut_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // One frame tick: origin for one cycle, then away; L moves on the second edge.
  task automatic frame_tick();
    h_cnt = 10'd0;   v_cnt = 10'd0;   tick_clk();
    h_cnt = 10'd700; v_cnt = 10'd500; tick_clk();
  endtask

  task automatic show_pixel(input logic [9:0] h, input logic [9:0] v,
                            input logic vl, input logic [11:0] d);
    h_cnt = h; v_cnt = v; valid = vl; mem_data = d;
    repeat (3) tick_clk();
  endtask

  initial begin
    rst = 1'b0; h_cnt = 10'd700; v_cnt = 10'd500; valid = 1'b0;
    fade_in = 1'b0; fade_out = 1'b0; mem_data = 12'h000;
    #1 rst = 1'b1;
    repeat (2) tick_clk();
    check("rst_def_addr", 32'(def_addr), 32'd0);
    check("rst_def_vga",  32'(def_vga),  32'h000);
    check("rst_def_done", 32'(def_done), 32'd0);
    check("rst_dut_addr", 32'(dut_addr), 32'd0);
    check("rst_dut_vga",  32'(dut_vga),  32'h000);
    check("rst_dut_busy", 32'(dut_busy), 32'd0);
    check("rst_dut_done", 32'(dut_done), 32'd0);
    rst = 1'b0;

    // Address mapping.
    h_cnt = 10'd0;   v_cnt = 10'd0;   tick_clk(); check("def_addr_0_0",     32'(def_addr), 32'd0);
    h_cnt = 10'd639; v_cnt = 10'd479; tick_clk(); check("def_addr_639_479", 32'(def_addr), 32'd76799);
    h_cnt = 10'd3;   v_cnt = 10'd2;   tick_clk(); check("def_addr_3_2",     32'(def_addr), 32'd321);
    check("dut_addr_outside", 32'(dut_addr), 32'd0);
    h_cnt = 10'd64;  v_cnt = 10'd32;  tick_clk(); check("def_addr_64_32",   32'(def_addr), 32'd5152);
    check("dut_addr_origin", 32'(dut_addr), 32'd0);
    h_cnt = 10'd65;  v_cnt = 10'd33;  tick_clk(); check("dut_addr_65_33",   32'(dut_addr), 32'd321);
    h_cnt = 10'd63;  v_cnt = 10'd32;  tick_clk(); check("dut_addr_63_32",   32'(dut_addr), 32'd0);
    h_cnt = 10'd700; v_cnt = 10'd500; tick_clk();

    // Fade in from BLACK.
    fade_in = 1'b1; tick_clk(); fade_in = 1'b0;
    check("fi_busy",     32'(dut_busy), 32'd1);
    check("fi_def_busy", 32'(def_busy), 32'd1);
    repeat (8) frame_tick();
    show_pixel(10'd100, 10'd100, 1'b1, 12'hFFF);
    check("fi_l8_vga", 32'(dut_vga), 32'h777);
    repeat (7) frame_tick();
    check("fi_l15_busy", 32'(dut_busy), 32'd1);
    check("fi_l15_done", 32'(dut_done), 32'd0);
    frame_tick();
    check("fi_done",      32'(dut_done), 32'd1);
    check("fi_busy_fall", 32'(dut_busy), 32'd0);
    tick_clk();
    check("fi_done_once", 32'(dut_done), 32'd0);

    // Pixel select at full brightness.
    show_pixel(10'd100, 10'd100, 1'b1, 12'hF0F); check("key_to_bg",   32'(dut_vga), 32'h123);
    show_pixel(10'd63,  10'd100, 1'b1, 12'h8A4); check("left_of_win", 32'(dut_vga), 32'h123);
    check("left_of_win_addr", 32'(dut_addr), 32'd0);
    show_pixel(10'd100, 10'd100, 1'b1, 12'h8A4); check("opaque_pixel", 32'(dut_vga), 32'h8A4);
    check("opaque_addr", 32'(dut_addr), 32'd21796);
    show_pixel(10'd700, 10'd500, 1'b0, 12'h8A4); check("valid_low",    32'(dut_vga), 32'h000);

    // Exact three-cycle latency from h/v to vga_data.
    h_cnt = 10'd64; v_cnt = 10'd32; valid = 1'b1;
    tick_clk();
    valid = 1'b0; h_cnt = 10'd700; v_cnt = 10'd500;
    check("lat_addr", 32'(dut_addr), 32'd0);
    tick_clk(); check("lat_cycle2", 32'(dut_vga), 32'h000);
    tick_clk(); check("lat_cycle3", 32'(dut_vga), 32'h8A4);
    tick_clk(); check("lat_cycle4", 32'(dut_vga), 32'h000);

    // Fade out, reverse at L=11, back to full.
    fade_out = 1'b1; tick_clk(); fade_out = 1'b0;
    check("fo_busy", 32'(dut_busy), 32'd1);
    repeat (5) frame_tick();
    show_pixel(10'd100, 10'd100, 1'b1, 12'hFFF); check("fo_l11_vga", 32'(dut_vga), 32'hAAA);
    fade_in = 1'b1; tick_clk(); fade_in = 1'b0;
    check("rev_no_done", 32'(dut_done), 32'd0);
    check("rev_busy",    32'(dut_busy), 32'd1);
    repeat (4) frame_tick();
    check("rev_l15_done", 32'(dut_done), 32'd0);
    frame_tick();
    check("rev_done",      32'(dut_done), 32'd1);
    check("rev_busy_fall", 32'(dut_busy), 32'd0);
    tick_clk();
    check("rev_done_once", 32'(dut_done), 32'd0);
    show_pixel(10'd100, 10'd100, 1'b1, 12'hFFF); check("rev_full_vga", 32'(dut_vga), 32'hFFF);

    // Full fade out to BLACK.
    fade_out = 1'b1; tick_clk(); fade_out = 1'b0;
    repeat (16) frame_tick();
    check("fo_done",      32'(dut_done), 32'd1);
    check("fo_busy_fall", 32'(dut_busy), 32'd0);

    // Reset in the middle of a fade-in.
    fade_in = 1'b1; tick_clk(); fade_in = 1'b0;
    repeat (3) frame_tick();
    show_pixel(10'd100, 10'd100, 1'b1, 12'hFFF); check("mid_l3_vga", 32'(dut_vga), 32'h222);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vga",  32'(dut_vga),  32'h000);
    check("mid_rst_busy", 32'(dut_busy), 32'd0);
    #1 rst = 1'b0;
    repeat (4) tick_clk();
    check("post_rst_vga",  32'(dut_vga),  32'h000);
    check("post_rst_busy", 32'(dut_busy), 32'd0);

    // Simultaneous requests in BLACK: fade_in wins.
    fade_in = 1'b1; fade_out = 1'b1; tick_clk(); fade_in = 1'b0; fade_out = 1'b0;
    check("both_busy", 32'(dut_busy), 32'd1);
    repeat (2) frame_tick();
    show_pixel(10'd100, 10'd100, 1'b1, 12'hFFF); check("both_l2_vga", 32'(dut_vga), 32'h111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scene_image_renderer.md
# scene_image_renderer

Parametrised full-scene image renderer for the VGA path. Maps the VGA pixel position to a source-image address at a power-of-two upscale and screen offset, and aligns the returned image data to the ROM latency. Adds chroma-key transparency, a background colour and a frame-synchronous fade-in/fade-out state machine. It is the common renderer for start, game and end scenes. It sits between the VGA counter and the scene image block ROM, and its output feeds the scene mux.

## Interface
Parameters:
- IMG_W, 320, source image width in pixels
- IMG_H, 240, source image height in pixels
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- SCALE_SHIFT, 1, upscale factor = 2^SCALE_SHIFT (0..3)
- X0, 0, screen x of image left edge
- Y0, 0, screen y of image top edge
- MEM_LAT, 1, ROM read latency in cycles (1..3)
- KEY_COLOR, 12'hF0F, source colour treated as transparent
- BG_COLOR, 12'h000, colour outside the image and under transparent pixels
- FADE_DIV, 4, frames per brightness step (≥1)

Ports:
- clk  in  1  pixel clock (25 MHz domain of h_cnt/v_cnt)
- rst  in  1  asynchronous, active-high reset
- h_cnt  in  10  VGA horizontal count
- v_cnt  in  10  VGA vertical count
- valid  in  1  VGA active-video flag
- fade_in  in  1  one-cycle request to fade to full brightness
- fade_out  in  1  one-cycle request to fade to black
- mem_data  in  12  ROM data for pixel_addr, MEM_LAT cycles after it
- pixel_addr  out  ADDR_W  registered ROM address
- vga_data  out  12  registered RGB444 output
- busy  out  1  high in FADE_IN or FADE_OUT
- done  out  1  one-cycle pulse when a fade completes

## Operation
- Window: h in [X0, X0+(IMG_W<<SCALE_SHIFT)), v in [Y0, Y0+(IMG_H<<SCALE_SHIFT)).
- Source coordinates: sx=(h_cnt-X0)>>SCALE_SHIFT, sy=(v_cnt-Y0)>>SCALE_SHIFT.
- Address: addr=sy*IMG_W+sx, computed at ADDR_W bits, always ≤ IMG_W*IMG_H-1. There is no modulo wrap. Outside the window, addr=0.
- Pixel select:
  - valid delayed low gives 12'h000.
  - Outside the window, or mem_data==KEY_COLOR, gives BG_COLOR.
  - Otherwise mem_data.
- Brightness L (5 bits, 0..16): each 4-bit channel out = (c*L)>>4. L=16 gives identity and L=0 gives black.
- Frame tick: one-cycle strobe on the first cycle where h_cnt==0 && v_cnt==0, using an edge detect on a registered compare. A divider counts FADE_DIV ticks per step.
- FSM states:
  - BLACK (L=0): fade_in moves to FADE_IN.
  - FADE_IN: L+1 per step. When L reaches 16, go to SHOW and pulse done.
  - SHOW (L=16): fade_out moves to FADE_OUT.
  - FADE_OUT: L-1 per step. When L reaches 0, go to BLACK and pulse done.
  - fade_in during FADE_OUT reverses to FADE_IN from the current L, with no done. fade_out during FADE_IN reverses likewise.
  - fade_in in SHOW and fade_out in BLACK are ignored.
  - fade_in and fade_out in the same cycle: fade_in wins.
- The divider is cleared on every state change. L changes only on a frame tick, so there is no mid-frame brightness change.

## Timing
- Reset values: pixel_addr=0, vga_data=0, busy=0, done=0, state BLACK, L=0, divider 0. Reset mid-fade aborts to these values.
- pixel_addr is registered 1 cycle after h_cnt/v_cnt.
- vga_data is registered 1+MEM_LAT+1 cycles after h_cnt/v_cnt (3 at default).
- The valid and in-window flags are delayed through a matching shift register.
- done is asserted in the cycle after the final L update. busy deasserts in the same cycle.
- A full fade takes 16*FADE_DIV frame ticks from the first tick after the request.

## Structure
- Shared package holds: the FSM state encoding (BLACK, FADE_IN, SHOW, FADE_OUT), the RGB444 width constant 12, and the VGA active size constants 640/480.
- One natural sub-module: rgb_dimmer. It is combinational, applying (c*L)>>4 per channel, and is reused by the scene mux.

## Test plan
- Defaults, h=0/v=0 → pixel_addr=0. h=639/v=479 → pixel_addr=76799. h=3/v=2 → pixel_addr=321 one cycle later.
- X0=64, Y0=32, SCALE_SHIFT=0:
  - h=63 → BG_COLOR, pixel_addr=0.
  - h=64/v=32 → pixel_addr=0 and in-window.
  - vga_data appears exactly 3 cycles after h/v.
- mem_data=12'hF0F at L=16 → BG_COLOR. mem_data=12'h8A4 → 12'h8A4. valid low → 12'h000.
- fade_in from BLACK, FADE_DIV=1:
  - L=8 after 8 frame ticks, so mem_data 12'hFFF gives 12'h777.
  - done pulses once after tick 16 and busy falls.
- fade_out in SHOW, then fade_in after 5 ticks (L=11) → reverses, reaches 16 after 5 more ticks, one done pulse.
- rst asserted mid FADE_IN → vga_data=0, L=0, busy=0 immediately. Simultaneous fade_in/fade_out in BLACK → FADE_IN.
